// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//
// Shares the register file's single write port between two writeback
// sources: src0 (ALU result) and src1 (memory load). Each source owns a
// one-entry holding slot with a valid/ready handshake. An arbiter drains
// the slots onto the write port, one write per cycle. The block also reports
// pending writes against two read addresses, so decode can stall on a hazard.
//
// Parameters
//   DW     data width
//   AW     register address width
//   RR_EN  1 = round-robin between sources, 0 = src1 always wins a conflict
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   s0_valid/ready      src0 handshake; s0_addr/s0_data carry the write
//   s1_valid/ready      src1 handshake; s1_addr/s1_data carry the write
//   wr_en/addr/data     register-file write port (W1/D1 plus enable)
//   chk_a, chk_b        read addresses to test for pending writes (R1/R2)
//   pend_a, pend_b      a write to chk_a / chk_b is still held in a slot
//   idle                both slots empty
module reg_write_arbiter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter bit          RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] chk_a,
  input  logic [AW-1:0] chk_b,
  output logic          pend_a,
  output logic          pend_b,
  output logic          idle
);

  // Holding slots
  logic          slot0_full;
  logic [AW-1:0] slot0_addr;
  logic [DW-1:0] slot0_data;
  logic          slot1_full;
  logic [AW-1:0] slot1_addr;
  logic [DW-1:0] slot1_data;

  // Relative age of the two entries: 1 when slot0 holds the older one.
  // Only meaningful while both slots are full.
  logic slot0_older;

  // Source granted most recently (0 = src0, 1 = src1).
  logic last_grant;

  logic pick1;
  logic grant0;
  logic grant1;
  logic load0;
  logic load1;

  // Conflict resolution for the case where both slots are full. Writes to
  // the same register must retire in arrival order, so age overrides both
  // round-robin and fixed priority.
  always_comb begin
    pick1 = 1'b0;
    if (slot0_addr == slot1_addr) begin
      pick1 = !slot0_older;
    end else if (RR_EN) begin
      pick1 = !last_grant;
    end else begin
      pick1 = 1'b1;
    end
  end

  assign grant0 = slot0_full && (!slot1_full || !pick1);
  assign grant1 = slot1_full && (!slot0_full || pick1);

  // A slot being drained this cycle can take a new entry at the same edge.
  assign s0_ready = !slot0_full || grant0;
  assign s1_ready = !slot1_full || grant1;

  // Writes to $0 complete their handshake but never occupy a slot.
  assign load0 = s0_valid && s0_ready && (s0_addr != '0);
  assign load1 = s1_valid && s1_ready && (s1_addr != '0);

  // Write port is driven straight from the granted slot and is all-zero
  // when nothing is pending.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (grant0) begin
      wr_en   = 1'b1;
      wr_addr = slot0_addr;
      wr_data = slot0_data;
    end else if (grant1) begin
      wr_en   = 1'b1;
      wr_addr = slot1_addr;
      wr_data = slot1_data;
    end
  end

  // Hazard checks include the slot being written this cycle; register $0
  // never has a pending write.
  assign pend_a = (chk_a != '0) &&
                  ((slot0_full && (slot0_addr == chk_a)) ||
                   (slot1_full && (slot1_addr == chk_a)));
  assign pend_b = (chk_b != '0) &&
                  ((slot0_full && (slot0_addr == chk_b)) ||
                   (slot1_full && (slot1_addr == chk_b)));

  assign idle = !slot0_full && !slot1_full;

  // Slot 0: a new entry takes priority over the clear caused by its grant,
  // which gives back-to-back acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_full <= 1'b0;
      slot0_addr <= '0;
      slot0_data <= '0;
    end else if (load0) begin
      slot0_full <= 1'b1;
      slot0_addr <= s0_addr;
      slot0_data <= s0_data;
    end else if (grant0) begin
      slot0_full <= 1'b0;
    end
  end

  // Slot 1: same behaviour as slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot1_full <= 1'b0;
      slot1_addr <= '0;
      slot1_data <= '0;
    end else if (load1) begin
      slot1_full <= 1'b1;
      slot1_addr <= s1_addr;
      slot1_data <= s1_data;
    end else if (grant1) begin
      slot1_full <= 1'b0;
    end
  end

  // Arbitration history. last_grant resets to src1 so src0 wins the first
  // tie. Age: simultaneous loads make slot0 the older entry; a slot loaded
  // while the other one stays full is the younger. A load into a slot whose
  // partner is empty leaves the flag alone, since the partner's later load
  // will set it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      slot0_older <= 1'b1;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end

      if (load0 && load1) begin
        slot0_older <= 1'b1;
      end else if (load0 && slot1_full && !grant1) begin
        slot0_older <= 1'b0;
      end else if (load1 && slot0_full && !grant0) begin
        slot0_older <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//
// Directed bench for reg_write_arbiter (DW=32, AW=5, RR_EN=1). A behavioural
// model tracks the two slots with global arrival sequence numbers and the
// last granted source; a compare process checks every DUT output against it
// each cycle at the falling edge. Hand-computed write orders and literal
// output values pin the model. Every write seen on the port is logged with
// its cycle number so directed tests can check order and spacing.
module tb_reg_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] chk_a;
  logic [AW-1:0] chk_b;
  logic          pend_a;
  logic          pend_b;
  logic          idle;

  int vectors     = 0;
  int miscompares = 0;

  reg_write_arbiter #(.DW(DW), .AW(AW), .RR_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .chk_a    (chk_a),
    .chk_b    (chk_b),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .idle     (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: per-slot contents plus the arrival sequence number used
  // for ordering same-register writes.
  bit            m_full [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int            m_seq  [2];
  int            m_last  = 1;
  int            seq_ctr = 0;
  bit            model_ok = 1'b0;

  // Write log captured from the DUT port.
  logic [AW+DW-1:0] dut_log[$];
  int               dut_cyc[$];
  int               cyc = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Which slot must be written this cycle: -1 none, else the source index.
  function automatic int model_pick();
    if (!m_full[0] && !m_full[1]) return -1;
    if (!m_full[1]) return 0;
    if (!m_full[0]) return 1;
    if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
    return 1 - m_last;
  endfunction

  // Model update on each rising edge: retire the granted entry, then take
  // in any handshakes, numbering arrivals so src0 precedes src1 at a tie.
  always @(posedge clk) begin : model_update
    int   p;
    logic r0, r1, a0, a1;
    p  = model_pick();
    r0 = !m_full[0] || (p == 0);
    r1 = !m_full[1] || (p == 1);
    if (rst) begin
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_last    = 1;
      model_ok  = 1'b1;
    end else begin
      if (p >= 0) begin
        m_full[p] = 1'b0;
        m_last    = p;
      end
      a0 = s0_valid && r0 && (s0_addr != '0);
      a1 = s1_valid && r1 && (s1_addr != '0);
      if (a0) begin
        m_full[0] = 1'b1; m_addr[0] = s0_addr; m_data[0] = s0_data;
        m_seq[0] = seq_ctr; seq_ctr++;
      end
      if (a1) begin
        m_full[1] = 1'b1; m_addr[1] = s1_addr; m_data[1] = s1_data;
        m_seq[1] = seq_ctr; seq_ctr++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int            p;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_pa, e_pb;
    cyc++;
    if (model_ok) begin
      p      = model_pick();
      e_en   = 1'b0;
      e_addr = '0;
      e_data = '0;
      if (p >= 0) begin
        e_en   = 1'b1;
        e_addr = m_addr[p];
        e_data = m_data[p];
      end
      e_pa = (chk_a != '0) && ((m_full[0] && m_addr[0] == chk_a) ||
                               (m_full[1] && m_addr[1] == chk_a));
      e_pb = (chk_b != '0) && ((m_full[0] && m_addr[0] == chk_b) ||
                               (m_full[1] && m_addr[1] == chk_b));
      check_output("model wr_en", wr_en, e_en);
      check_output("model wr_addr", wr_addr, e_addr);
      check_output("model wr_data", wr_data, e_data);
      check_output("model s0_ready", s0_ready, !m_full[0] || (p == 0));
      check_output("model s1_ready", s1_ready, !m_full[1] || (p == 1));
      check_output("model pend_a", pend_a, e_pa);
      check_output("model pend_b", pend_b, e_pb);
      check_output("model idle", idle, !m_full[0] && !m_full[1]);
      if (wr_en === 1'b1) begin
        dut_log.push_back({wr_addr, wr_data});
        dut_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input logic v0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic v1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
  endtask

  task automatic check_write(input int idx, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    logic [AW+DW-1:0] e;
    if (idx < dut_log.size()) begin
      e = dut_log[idx];
      check_output($sformatf("write%0d addr", idx), e[AW+DW-1:DW], a);
      check_output($sformatf("write%0d data", idx), e[DW-1:0], d);
    end else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL write%0d missing: got %0d writes, required more",
               idx, dut_log.size());
    end
  endtask

  initial begin : main
    int   idx0, idx1, n;
    logic r0, r1;

    // Reset held for two edges while src0 presents a write to r3.
    rst = 1'b1; chk_a = '0; chk_b = '0;
    apply_stimulus(1'b1, 5'd3, 32'd7, 1'b0, '0, '0);
    step();
    @(negedge clk);
    check_output("reset idle", idle, 1'b1);
    check_output("reset wr_en", wr_en, 1'b0);
    check_output("reset s0_ready", s0_ready, 1'b1);
    step();
    rst = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    @(negedge clk);
    check_output("post-reset wr_en", wr_en, 1'b0);
    check_output("post-reset idle", idle, 1'b1);

    // Single write: r1 <= 32, visible on the port the cycle after accept.
    dut_log.delete();
    apply_stimulus(1'b1, 5'd1, 32'd32, 1'b0, '0, '0);
    chk_a = 5'd1;
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check_output("single wr_en", wr_en, 1'b1);
    check_output("single wr_addr", wr_addr, 5'd1);
    check_output("single wr_data", wr_data, 32'd32);
    check_output("single pend_a", pend_a, 1'b1);
    step();
    @(negedge clk);
    check_output("single idle after", idle, 1'b1);
    check_output("single pend_a after", pend_a, 1'b0);
    chk_a = '0;

    // Simultaneous pair from reset: src0 wins (last_grant starts on src1).
    // A lone src0 write then leaves last_grant on src0, so the next pair
    // goes src1 first.
    apply_reset();
    dut_log.delete();
    apply_stimulus(1'b1, 5'd3, 32'd25, 1'b1, 5'd4, 32'd77);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) step();
    apply_stimulus(1'b1, 5'd9, 32'd5, 1'b0, '0, '0);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) step();
    apply_stimulus(1'b1, 5'd3, 32'd26, 1'b1, 5'd4, 32'd78);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) step();
    check_output("pair write count", dut_log.size(), 5);
    check_write(0, 5'd3, 32'd25);
    check_write(1, 5'd4, 32'd77);
    check_write(2, 5'd9, 32'd5);
    check_write(3, 5'd4, 32'd78);
    check_write(4, 5'd3, 32'd26);

    // Same register, same edge: slot0 is older and goes first even though
    // round-robin now favours src1. Then r6 from src1 arrives one cycle
    // before r6 from src0 (src0 busy with r7) and must retire first.
    dut_log.delete();
    chk_b = 5'd6;
    apply_stimulus(1'b1, 5'd5, 32'd10, 1'b1, 5'd5, 32'd20);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) step();
    apply_stimulus(1'b1, 5'd7, 32'd50, 1'b1, 5'd6, 32'd1);
    step();
    apply_stimulus(1'b1, 5'd6, 32'd2, 1'b0, '0, '0);
    @(negedge clk);
    check_output("order s0_ready", s0_ready, 1'b1);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check_output("order pend_b", pend_b, 1'b1);
    repeat (3) step();
    chk_b = '0;
    check_output("order write count", dut_log.size(), 5);
    check_write(0, 5'd5, 32'd10);
    check_write(1, 5'd5, 32'd20);
    check_write(2, 5'd7, 32'd50);
    check_write(3, 5'd6, 32'd1);
    check_write(4, 5'd6, 32'd2);

    // Writes to $0 handshake but never reach the port.
    dut_log.delete();
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'd99);
    @(negedge clk);
    check_output("zero s1_ready", s1_ready, 1'b1);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check_output("zero wr_en", wr_en, 1'b0);
    check_output("zero idle", idle, 1'b1);
    check_output("zero pend_a", pend_a, 1'b0);
    step();
    check_output("zero write count", dut_log.size(), 0);

    // Both sources streaming: src0 sends r1,r3,r5,r7 and src1 sends
    // r2,r4,r6,r8 (data = 11*addr). Starting from reset the port must show
    // r1..r8 in order, one write per cycle.
    apply_reset();
    dut_log.delete();
    dut_cyc.delete();
    idx0 = 0;
    idx1 = 0;
    n    = 0;
    while ((idx0 < 4 || idx1 < 4) && n < 40) begin
      apply_stimulus(idx0 < 4, AW'(2 * idx0 + 1), DW'(11 * (2 * idx0 + 1)),
                     idx1 < 4, AW'(2 * idx1 + 2), DW'(11 * (2 * idx1 + 2)));
      @(negedge clk);
      r0 = s0_ready;
      r1 = s1_ready;
      step();
      if (s0_valid && r0) idx0++;
      if (s1_valid && r1) idx1++;
      n++;
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    check_output("stream src0 accepts", idx0, 4);
    check_output("stream src1 accepts", idx1, 4);
    for (int i = 0; i < 10 && idle !== 1'b1; i++) step();
    step();
    check_output("stream write count", dut_log.size(), 8);
    for (int i = 0; i < 8; i++) check_write(i, AW'(i + 1), DW'(11 * (i + 1)));
    if (dut_cyc.size() == 8) begin
      check_output("stream back-to-back", dut_cyc[7] - dut_cyc[0], 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
